// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_pkg
//  Purpose  : Shared types for the one-hot sequencer: stepping modes and
//             bounce direction.
//  Revision : 1.0  initial release
// ============================================================================
package onehot_pkg;

    // Stepping behaviour applied on each prescaler tick
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    // Travel direction remembered between ticks (used by BOUNCE)
    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

endpackage : onehot_pkg
`default_nettype wire

// File: rtl/onehot_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_sequencer_if
//  Purpose  : Control and display bundle between the switch/control side
//             (master) and the one-hot sequencer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface onehot_sequencer_if
    import onehot_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) ();

    logic                    en_i;
    mode_t                   mode_i;
    logic [DIV_W-1:0]        div_i;
    logic                    load_i;
    logic [SEL_W-1:0]        sel_i;
    logic [(1<<SEL_W)-1:0]   onehot_o;
    logic [SEL_W-1:0]        idx_o;
    logic                    wrap_o;

    // Control side: drives configuration, observes the LED vector
    modport master (
        output en_i, mode_i, div_i, load_i, sel_i,
        input  onehot_o, idx_o, wrap_o
    );

    // Sequencer side
    modport slave (
        input  en_i, mode_i, div_i, load_i, sel_i,
        output onehot_o, idx_o, wrap_o
    );

endinterface : onehot_sequencer_if
`default_nettype wire

// File: rtl/onehot_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_prescaler
//  Purpose  : Programmable rate divider. Produces a one-cycle tick every
//             div_i+1 enabled cycles; clr_i restarts the count.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_prescaler #(
    parameter int DIV_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en_i,
    input  wire logic             clr_i,
    input  wire logic [DIV_W-1:0] div_i,
    output logic                  tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // The compare always uses the live div value. If div drops below the
    // current count there is no early tick: the counter runs on and wraps
    // through zero before it can match again.
    assign tick_o = en_i & ~clr_i & (cnt_q == div_i);

    // Next count: clear wins, then tick restart, then increment, else hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : onehot_prescaler
`default_nettype wire

// File: rtl/onehot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_sequencer
//  Purpose  : Registered N = 2**SEL_W one-hot driver. The hot position is
//             loaded from a binary select or stepped (rotate left/right,
//             bounce) at a prescaled rate. Also exports the binary index and
//             a one-cycle wrap/reversal pulse.
//  Revision : 1.0  initial release
// ============================================================================
module onehot_sequencer
    import onehot_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    onehot_sequencer_if.slave  bus
);

    localparam int              c_N        = 1 << SEL_W;
    localparam logic [SEL_W-1:0] c_IDX_LAST = SEL_W'(c_N - 1);
    localparam logic [c_N-1:0]   c_ONE      = c_N'(1);

    logic [SEL_W-1:0] idx_q,    idx_d;
    dir_t             dir_q,    dir_d;
    logic             wrap_q,   wrap_d;
    logic [c_N-1:0]   onehot_q, onehot_d;
    logic             w_tick;

    // Rate divider; a load restarts the step period
    onehot_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.en_i),
        .clr_i  (bus.load_i),
        .div_i  (bus.div_i),
        .tick_o (w_tick)
    );

    // Next position/direction/wrap: load beats a tick step; mode only matters on a tick
    always_comb begin
        idx_d  = idx_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        if (bus.load_i) begin
            idx_d = bus.sel_i;
        end else if (w_tick) begin
            case (bus.mode_i)
                MODE_ROT_L: begin
                    idx_d  = idx_q + SEL_W'(1);
                    dir_d  = DIR_UP;
                    wrap_d = (idx_q == c_IDX_LAST);
                end
                MODE_ROT_R: begin
                    idx_d  = idx_q - SEL_W'(1);
                    dir_d  = DIR_DN;
                    wrap_d = (idx_q == '0);
                end
                MODE_BOUNCE: begin
                    // Reversal happens at the ends instead of wrapping around
                    if (dir_q == DIR_UP) begin
                        if (idx_q != c_IDX_LAST) begin
                            idx_d = idx_q + SEL_W'(1);
                        end else begin
                            idx_d  = idx_q - SEL_W'(1);
                            dir_d  = DIR_DN;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        if (idx_q != '0) begin
                            idx_d = idx_q - SEL_W'(1);
                        end else begin
                            idx_d  = idx_q + SEL_W'(1);
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end
        // Decode from the next index so the vector moves on the same edge as idx
        onehot_d = c_ONE << idx_d;
    end

    // State registers; onehot resets to bit 0 so exactly one bit is always set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            dir_q    <= DIR_UP;
            wrap_q   <= 1'b0;
            onehot_q <= c_ONE;
        end else begin
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            onehot_q <= onehot_d;
        end
    end

    assign bus.onehot_o = onehot_q;
    assign bus.idx_o    = idx_q;
    assign bus.wrap_o   = wrap_q;

endmodule : onehot_sequencer
`default_nettype wire
